// File: rtl/mux_arbiter.sv
// Round-robin arbiter for two requesters sharing a 2:1 data mux.
// Ports:
//   clk, rst              clock and async active-high reset
//   req_a/req_b           level-sensitive requests
//   data_a/data_b         request data
//   gnt_a/gnt_b, sel      grant and mux select
//   out_data, out_valid   registered mux output and strobe
module mux_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

   state_t           state;
   state_t           nxt;
   logic [CW-1:0]    burst_cnt;
   logic             last_owner;  // 1 = B owned the channel last
   logic             sel_q;
   logic             xfer;
   logic             at_limit;
   logic [WIDTH-1:0] xdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: begin
            if (req_a && req_b) begin
               nxt = last_owner ? GRANT_A : GRANT_B;
            end else if (req_a) begin
               nxt = GRANT_A;
            end else if (req_b) begin
               nxt = GRANT_B;
            end
         end
         GRANT_A: begin
            if (!req_a) begin
               nxt = req_b ? GRANT_B : IDLE;
            end else if (at_limit && req_b) begin
               nxt = GRANT_B;
            end
         end
         GRANT_B: begin
            if (!req_b) begin
               nxt = req_a ? GRANT_A : IDLE;
            end else if (at_limit && req_a) begin
               nxt = GRANT_A;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_a    = (state == GRANT_A);
      gnt_b    = (state == GRANT_B);
      xfer     = (gnt_a && req_a) || (gnt_b && req_b);
      xdata    = gnt_b ? data_b : data_a;
      at_limit = (burst_cnt == LAST);
   end

   assign sel = sel_q;

   // sel is held in IDLE, so it only moves on entry to a grant state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt  <= '0;
         last_owner <= 1'b1;
         sel_q      <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= xdata;
         end
         // wrap at the limit keeps a lone requester granted
         if (nxt != state) begin
            burst_cnt <= '0;
         end else if (xfer) begin
            burst_cnt <= at_limit ? '0 : burst_cnt + 1'b1;
         end
         if (nxt == GRANT_A && state != GRANT_A) begin
            last_owner <= 1'b0;
            sel_q      <= 1'b0;
         end
         if (nxt == GRANT_B && state != GRANT_B) begin
            last_owner <= 1'b1;
            sel_q      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: directed stimulus pushes expected
// words, a negedge monitor pops and compares on every out_valid.
module tb_mux_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_a = 1'b0;
   logic       req_b = 1'b0;
   logic [7:0] data_a = '0;
   logic [7:0] data_b = '0;
   logic       gnt_a;
   logic       gnt_b;
   logic       sel;
   logic [7:0] out_data;
   logic       out_valid;

   logic [7:0] q[$];
   logic [7:0] mon_exp;
   int n_cmp = 0;
   int n_bad = 0;

   mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
      .clk(clk),
      .rst(rst),
      .req_a(req_a),
      .data_a(data_a),
      .req_b(req_b),
      .data_b(data_b),
      .gnt_a(gnt_a),
      .gnt_b(gnt_b),
      .sel(sel),
      .out_data(out_data),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("excl", 32'(gnt_a && gnt_b), 0);
         if (out_valid) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_word: got %0h want none",
                        out_data);
            end else begin
               mon_exp = q.pop_front();
               chk("out_data", 32'(out_data), 32'(mon_exp));
            end
         end
      end
   end

   initial begin
      // test 1: reset state, then reset mid-burst
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt_a", 32'(gnt_a), 0);
      chk("rst_gnt_b", 32'(gnt_b), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      rst = 1'b0;
      req_a = 1'b1;
      data_a = 8'h5A;
      tick();
      chk("t1_gnt", 32'(gnt_a), 1);
      tick();
      chk("t1_valid_pre", 32'(out_valid), 1);
      chk("t1_data_pre", 32'(out_data), 32'h5A);
      #1 rst = 1'b1;
      #1;
      chk("t1_rst_gnt", 32'(gnt_a), 0);
      chk("t1_rst_valid", 32'(out_valid), 0);
      chk("t1_rst_data", 32'(out_data), 0);
      chk("t1_rst_sel", 32'(sel), 0);
      req_a = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1_idle_gnt", 32'({gnt_a, gnt_b}), 0);
         chk("t1_idle_valid", 32'(out_valid), 0);
         chk("t1_idle_data", 32'(out_data), 0);
      end

      // test 2: single requester, three words
      req_a = 1'b1;
      data_a = 8'h11;
      tick();
      chk("t2_gnt", 32'(gnt_a), 1);
      chk("t2_sel", 32'(sel), 0);
      chk("t2_novalid", 32'(out_valid), 0);
      q.push_back(8'h11);
      tick();
      data_a = 8'h22;
      q.push_back(8'h22);
      tick();
      data_a = 8'h33;
      q.push_back(8'h33);
      tick();
      chk("t2_valid3", 32'(out_valid), 1);
      req_a = 1'b0;
      tick();
      chk("t2_idle", 32'({gnt_a, gnt_b}), 0);
      chk("t2_sel_idle", 32'(sel), 0);
      chk("t2_valid_off", 32'(out_valid), 0);
      chk("t2_q", 32'(q.size()), 0);

      // tests 3/4: tie after reset, then burst rotation
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.push_back(8'hA1); q.push_back(8'hA2);
      q.push_back(8'hA3); q.push_back(8'hA4);
      q.push_back(8'hB5); q.push_back(8'hB6);
      q.push_back(8'hB7); q.push_back(8'hB8);
      q.push_back(8'hA9); q.push_back(8'hAA);
      q.push_back(8'hAB); q.push_back(8'hAC);
      for (int i = 0; i <= 12; i++) begin
         req_a = 1'b1;
         req_b = 1'b1;
         data_a = 8'hA0 + 8'(i);
         data_b = 8'hB0 + 8'(i);
         tick();
         if (i < 4 || (i >= 8 && i < 12)) begin
            chk("t4_gnt_a", 32'({gnt_a, gnt_b, sel}), 32'b100);
         end else begin
            chk("t4_gnt_b", 32'({gnt_a, gnt_b, sel}), 32'b011);
         end
         if (i >= 1) begin
            chk("t4_valid", 32'(out_valid), 1);
         end
      end
      req_a = 1'b0;
      req_b = 1'b0;
      tick();
      chk("t4_idle", 32'({gnt_a, gnt_b}), 0);
      chk("t4_valid_off", 32'(out_valid), 0);
      chk("t4_sel_hold", 32'(sel), 1);
      tick();
      chk("t4_q", 32'(q.size()), 0);

      // test 5: lone long burst on B
      for (int i = 1; i <= 10; i++) begin
         q.push_back(8'hC0 + 8'(i));
      end
      for (int i = 0; i <= 10; i++) begin
         req_b = 1'b1;
         data_b = 8'hC0 + 8'(i);
         tick();
         chk("t5_gnt", 32'({gnt_a, gnt_b, sel}), 32'b011);
         if (i >= 1) begin
            chk("t5_valid", 32'(out_valid), 1);
         end
      end
      req_b = 1'b0;
      tick();
      chk("t5_idle", 32'({gnt_a, gnt_b}), 0);
      chk("t5_sel_hold", 32'(sel), 1);
      chk("t5_valid_off", 32'(out_valid), 0);
      tick();
      chk("t5_q", 32'(q.size()), 0);

      // test 6: A released mid-burst while B waits
      q.push_back(8'hD1);
      q.push_back(8'hD2);
      q.push_back(8'hE4);
      req_a = 1'b1;
      req_b = 1'b1;
      for (int i = 0; i <= 2; i++) begin
         data_a = 8'hD0 + 8'(i);
         data_b = 8'hE0 + 8'(i);
         tick();
         chk("t6_gnt_a", 32'({gnt_a, gnt_b, sel}), 32'b100);
      end
      req_a = 1'b0;
      data_b = 8'hE3;
      tick();
      chk("t6_gnt_b", 32'({gnt_a, gnt_b, sel}), 32'b011);
      chk("t6_no_pulse", 32'(out_valid), 0);
      data_b = 8'hE4;
      tick();
      chk("t6_b_valid", 32'(out_valid), 1);
      req_b = 1'b0;
      tick();
      chk("t6_idle", 32'({gnt_a, gnt_b}), 0);
      tick();
      chk("t6_q", 32'(q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 2:1 data multiplexer. Two requesters (A, B) compete for one output channel. The block grants one requester at a time and drives the mux select. It registers the selected data word with a valid strobe. A per-grant burst limit prevents starvation. It sits between two producer units and a single downstream consumer in the CPU datapath.

Parameters:
WIDTH, 8, data width of each input and of the output
MAX_BURST, 4, max consecutive transfers per grant while the other side is requesting (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_a  input  1  requester A wants the channel; a transfer occurs each cycle req_a && gnt_a
data_a  input  WIDTH  requester A data, sampled on transfer cycles
req_b  input  1  requester B request, same rules as A
data_b  input  WIDTH  requester B data
gnt_a  output  1  A owns the channel (registered)
gnt_b  output  1  B owns the channel (registered)
sel  output  1  mux select: 0 = A, 1 = B (registered)
out_data  output  WIDTH  registered mux output
out_valid  output  1  out_data holds a new word this cycle

Behaviour:
- Reset (async, immediate): state=IDLE, gnt_a=gnt_b=0, sel=0, out_data=0, out_valid=0, burst_cnt=0, last_owner=B (so A wins the first tie). An in-flight transfer is discarded; no out_valid pulse follows reset release.
- States: IDLE, GRANT_A, GRANT_B. Outputs decode from state: gnt_a=(GRANT_A), gnt_b=(GRANT_B), sel=(GRANT_B). sel keeps its last value in IDLE; it is 0 after reset.
- gnt_a and gnt_b are never high together.
- IDLE transitions:
  - only req_a -> GRANT_A
  - only req_b -> GRANT_B
  - both -> the side that is not last_owner
  - none -> stay in IDLE
- Grant latency: a request sampled at edge N gives the grant in the cycle after edge N. The first transfer is that cycle.
- Transfer in GRANT_X: a transfer occurs when req_x=1. At that edge out_data<=data_x, out_valid<=1, burst_cnt<=burst_cnt+1. In any cycle without a transfer, out_valid<=0 and out_data holds its value.
- Leaving GRANT_X, evaluated every edge in priority order:
  1. req_x=0 -> GRANT_other if req_other=1, else IDLE. No transfer this cycle.
  2. A transfer with burst_cnt==MAX_BURST-1 and req_other=1 -> GRANT_other (burst limit).
  3. Otherwise stay in GRANT_X.
- Switching between grants is direct, with no idle bubble.
- burst_cnt clears to 0 on every state change. If it reaches MAX_BURST-1 and req_other=0, it wraps to 0 and the grant continues.
- last_owner updates to X on every entry into GRANT_X.
- Requests are level-sensitive. Dropping req_x releases the channel. Raising it again later competes under round-robin rules.
- Throughput is one word per cycle with a continuous request. Data latency is one cycle from transfer edge to out_valid.

Test Plan:
1. Reset: assert rst mid-burst (GRANT_A, out_valid=1) -> all outputs 0 immediately, state IDLE. After release with no requests, outputs stay 0.
2. Single requester: req_a=1 with data_a=0x11,0x22,0x33 over 3 cycles, then drop -> gnt_a high 1 cycle after req. out_data=0x11,0x22,0x33 with out_valid high for exactly 3 consecutive cycles. Returns to IDLE with sel=0.
3. Simultaneous first request: req_a=req_b=1 from IDLE after reset -> A granted first (last_owner=B). sel=0.
4. Burst limit: MAX_BURST=4, req_a and req_b held high -> A makes 4 transfers, then gnt_b rises the next cycle with no gap. B makes 4, then A makes 4. out_valid stays continuously high. gnt_a and gnt_b are never high together.
5. Lone long burst: only req_b held for 10 cycles -> gnt_b stays high throughout with 10 transfers. Counter wrap does not release the grant.
6. Mid-burst release: in GRANT_A, drop req_a while req_b=1 -> next cycle gnt_b=1, sel=1. No out_valid pulse for the release cycle. The next word carries data_b.
